// File: rtl/rgb_breathe_pwm.sv
// Three-channel LED breathing PWM: fade up, hold, fade down, hold dark, rotate channel.
// Optional RGB_BREATHE_GAMMA_EN applies a truncated square-law duty curve.
module rgb_breathe_pwm #(
  parameter int PRESCALE     = 188,
  parameter int PWM_BITS     = 8,
  parameter int STEP_DIV     = 4,
  parameter int HOLD_PERIODS = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_enable,
  output logic       io_pwm0,
  output logic       io_pwm1,
  output logic       io_pwm2,
  output logic [1:0] io_channel,
  output logic [1:0] io_phase
);
  localparam int PRE_W  = (PRESCALE > 1)     ? $clog2(PRESCALE)     : 1;
  localparam int STEP_W = (STEP_DIV > 1)     ? $clog2(STEP_DIV)     : 1;
  localparam int HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] DUTY_TOP = DUTY_MAX - PWM_BITS'(1);

  typedef enum logic [1:0] {S_UP, S_HOLD_HI, S_DOWN, S_HOLD_LO} state_t;

  state_t              r_state, w_state_nxt;
  logic [PRE_W-1:0]    r_pre_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt, r_duty, w_duty_eff;
  logic [STEP_W-1:0]   r_step_cnt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [1:0]          r_channel;
  logic [2:0]          r_pwm, w_pwm_nxt;
  logic                w_tick, w_period_end, w_step_last, w_hold_last;

  assign w_tick       = io_enable && (r_pre_cnt == PRE_W'(PRESCALE - 1));
  assign w_period_end = w_tick && (r_pwm_cnt == DUTY_MAX);
  assign w_step_last  = (r_step_cnt == STEP_W'(STEP_DIV - 1));
  assign w_hold_last  = (r_hold_cnt == HOLD_W'(HOLD_PERIODS - 1));

`ifdef RGB_BREATHE_GAMMA_EN
  logic [2*PWM_BITS-1:0] w_duty_sq;
  assign w_duty_sq  = {{PWM_BITS{1'b0}}, r_duty} * {{PWM_BITS{1'b0}}, r_duty};
  assign w_duty_eff = w_duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign w_duty_eff = r_duty;
`endif

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_UP;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state, only ever moves on a PWM period boundary
  always_comb begin
    w_state_nxt = r_state;
    if (w_period_end) begin
      case (r_state)
        S_UP:      if (w_step_last && r_duty == DUTY_TOP)      w_state_nxt = S_HOLD_HI;
        S_HOLD_HI: if (w_hold_last)                            w_state_nxt = S_DOWN;
        S_DOWN:    if (w_step_last && r_duty == PWM_BITS'(1))  w_state_nxt = S_HOLD_LO;
        S_HOLD_LO: if (w_hold_last)                            w_state_nxt = S_UP;
        default:                                               w_state_nxt = S_UP;
      endcase
    end
  end

  // FSM: output decode, only the active channel sees the compare
  always_comb begin
    w_pwm_nxt = 3'b000;
    case (r_channel)
      2'd0:    w_pwm_nxt[0] = (r_pwm_cnt < w_duty_eff);
      2'd1:    w_pwm_nxt[1] = (r_pwm_cnt < w_duty_eff);
      2'd2:    w_pwm_nxt[2] = (r_pwm_cnt < w_duty_eff);
      default: w_pwm_nxt    = 3'b000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pre_cnt  <= '0;
      r_pwm_cnt  <= '0;
      r_duty     <= '0;
      r_step_cnt <= '0;
      r_hold_cnt <= '0;
      r_channel  <= 2'd0;
      r_pwm      <= 3'b000;
    end else if (io_enable) begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
      r_pwm     <= w_pwm_nxt;
      if (w_tick) r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      if (w_period_end) begin
        case (r_state)
          S_UP, S_DOWN: begin
            if (w_step_last) begin
              r_step_cnt <= '0;
              r_duty     <= (r_state == S_UP) ? r_duty + PWM_BITS'(1) : r_duty - PWM_BITS'(1);
            end else begin
              r_step_cnt <= r_step_cnt + STEP_W'(1);
            end
          end
          default: begin
            if (w_hold_last) begin
              r_hold_cnt <= '0;
              // duty is already 0 here, so the new channel starts dark
              if (r_state == S_HOLD_LO) r_channel <= (r_channel == 2'd2) ? 2'd0 : r_channel + 2'd1;
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
          end
        endcase
      end
    end else begin
      r_pwm <= 3'b000;
    end
  end

  assign io_pwm0    = r_pwm[0];
  assign io_pwm1    = r_pwm[1];
  assign io_pwm2    = r_pwm[2];
  assign io_channel = r_channel;
  assign io_phase   = r_state;
endmodule

// File: tb/tb_rgb_breathe_pwm.sv
// Randomised bench for rgb_breathe_pwm; reference model derives everything in closed
// form from the count of enabled cycles since reset.
module tb_rgb_breathe_pwm;
  localparam int P   = 2;
  localparam int B   = 3;
  localparam int S   = 1;
  localparam int H   = 2;
  localparam int MX  = (1 << B) - 1;
  localparam int TPP = 1 << B;
  localparam int PC  = P * TPP;
  localparam int L   = 2 * MX * S + 2 * H;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       io_enable = 1'b0;
  logic       io_pwm0, io_pwm1, io_pwm2;
  logic [1:0] io_channel, io_phase;

  int         checks = 0;
  int         errors = 0;
  longint     t = 0;
  logic [2:0] exp_pins = 3'b000;

  rgb_breathe_pwm #(.PRESCALE(P), .PWM_BITS(B), .STEP_DIV(S), .HOLD_PERIODS(H)) dut (
    .clock(clock), .reset(reset), .io_enable(io_enable),
    .io_pwm0(io_pwm0), .io_pwm1(io_pwm1), .io_pwm2(io_pwm2),
    .io_channel(io_channel), .io_phase(io_phase)
  );

  always #5 clock = ~clock;

  function automatic int m_of(longint tt);
    return int'((tt / PC) % L);
  endfunction

  function automatic int phase_at(longint tt);
    int m = m_of(tt);
    if (m < MX * S)         return 0;
    if (m < MX * S + H)     return 1;
    if (m < 2 * MX * S + H) return 2;
    return 3;
  endfunction

  function automatic int duty_at(longint tt);
    int m = m_of(tt);
    case (phase_at(tt))
      0:       return m / S;
      1:       return MX;
      2:       return MX - (m - MX * S - H) / S;
      default: return 0;
    endcase
  endfunction

  function automatic int chan_at(longint tt);
    return int'((tt / (PC * L)) % 3);
  endfunction

  function automatic int eff(int d);
`ifdef RGB_BREATHE_GAMMA_EN
    return (d * d) >> B;
`else
    return d;
`endif
  endfunction

  function automatic logic [2:0] pins_at(longint tt);
    logic [2:0] p = 3'b000;
    p[chan_at(tt)] = (int'((tt / P) % TPP) < eff(duty_at(tt)));
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0d obs=%0d exp=%0d", tag, t, obs, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs held across it, then compare.
  task automatic step();
    @(posedge clock);
    if (reset) begin
      t = 0;
      exp_pins = 3'b000;
    end else if (io_enable) begin
      exp_pins = pins_at(t);
      t++;
    end else begin
      exp_pins = 3'b000;
    end
    #1;
    chk("pwm0", 32'(io_pwm0), 32'(exp_pins[0]));
    chk("pwm1", 32'(io_pwm1), 32'(exp_pins[1]));
    chk("pwm2", 32'(io_pwm2), 32'(exp_pins[2]));
    chk("phase", 32'(io_phase), 32'(phase_at(t)));
    chk("channel", 32'(io_channel), 32'(chan_at(t)));
  endtask

  initial begin
    int cnt, expw, guard;
    reset = 1'b1; io_enable = 1'b1;
    repeat (5) step();
    reset = 1'b0;

    // pulse width per period across the first ramp and into the hold
    for (int k = 0; k < 9; k++) begin
      expw = P * eff(duty_at(t));
      cnt = 0;
      repeat (PC) begin
        step();
        cnt += int'(io_pwm0);
      end
      chk("pulse_width", 32'(cnt), 32'(expw));
    end

    // randomised enable gating, with occasional long freezes
    repeat (1200) begin
      if ($urandom_range(0, 99) == 0) begin
        io_enable = 1'b0;
        repeat (50) step();
      end
      io_enable = ($urandom_range(0, 7) != 0);
      step();
    end

    // reset while channel 2 is fading down
    io_enable = 1'b1;
    guard = 0;
    while (!(chan_at(t) == 2 && phase_at(t) == 2) && guard < 3000) begin
      step();
      guard++;
    end
    chk("reach_ch2_down", 32'(guard < 3000), 32'd1);
    repeat ($urandom_range(1, 20)) step();
    reset = 1'b1;
    step();
    chk("midreset_channel", 32'(io_channel), 32'd0);
    chk("midreset_phase", 32'(io_phase), 32'd0);
    reset = 1'b0;
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
